uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 79 +++++++
 tb/tb_uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-in handshake and serial line bundle for uart_tx
//   valid_in/byte_in  : driven by the master, sampled at the acceptance edge
//   ready_out         : high only while the transmitter is idle
//   uart_txd_out      : registered serial line, idles high
interface uart_tx_if;
  logic       valid_in;
  logic [7:0] byte_in;
  logic       uart_txd_out;
  logic       ready_out;
  modport master (output valid_in, byte_in, input uart_txd_out, ready_out);
  modport slave (input valid_in, byte_in, output uart_txd_out, ready_out);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, one bit every CLKS_PER_BAUD clocks
//   clk_in : rising-edge clock
//   rst_in : synchronous active-high reset, aborts any frame in progress
//   bus    : uart_tx_if.slave (valid_in, byte_in, ready_out, uart_txd_out)
module uart_tx #(
  parameter int CLKS_PER_BAUD = 33
) (
  input  logic      clk_in,
  input  logic      rst_in,
  uart_tx_if.slave  bus
);
  localparam int W = $clog2(CLKS_PER_BAUD);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           last;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end
  // txd_d is the level of the cycle the FSM is moving into, so the line
  // changes exactly on bit boundaries straight from a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    last    = baud_q == W'(CLKS_PER_BAUD - 1);
    case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = ~bus.valid_in;
        if (bus.valid_in) begin
          state_d = START;
          shift_d = bus.byte_in;
        end
      end
      START: if (last) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = shift_q[0];
      end
      DATA: if (last) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          txd_d   = shift_q[1];
        end
      end
      STOP: if (last) begin
        state_d = IDLE;
        baud_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.uart_txd_out = txd_q;
  assign bus.ready_out    = state_q == IDLE;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random-stimulus bench for uart_tx at 33 and 4 clocks per bit
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  uart_tx_if bd ();
  uart_tx_if bs ();
  uart_tx #(.CLKS_PER_BAUD(33)) u_d (.clk_in(clk), .rst_in(rst), .bus(bd));
  uart_tx #(.CLKS_PER_BAUD(4))  u_s (.clk_in(clk), .rst_in(rst), .bus(bs));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic line(input bit s);
    return s ? bs.uart_txd_out : bd.uart_txd_out;
  endfunction
  function automatic logic rdy(input bit s);
    return s ? bs.ready_out : bd.ready_out;
  endfunction
  task automatic drive(input bit s, input logic v, input logic [7:0] b);
    if (s) begin
      bs.valid_in = v;
      bs.byte_in  = b;
    end else begin
      bd.valid_in = v;
      bd.byte_in  = b;
    end
  endtask
  // One-cycle request, then the whole frame is compared against {stop, byte, start}
  // at the first and last cycle of every bit, with random valid/byte noise while busy.
  task automatic frame(input bit s, input logic [7:0] b);
    int c = s ? 4 : 33;
    int low_rdy = 0;
    logic [9:0] exp_f = {1'b1, b, 1'b0};
    logic [9:0] first_v = '0;
    logic [9:0] last_v = '0;
    @(negedge clk);
    check("rdy_pre", rdy(s), 1);
    drive(s, 1'b1, b);
    @(posedge clk);
    #1 drive(s, 1'b0, 8'($urandom));
    for (int t = 0; t < 10 * c; t++) begin
      @(negedge clk);
      if (t % c == 0) first_v[t / c] = line(s);
      if (t % c == c - 1) last_v[t / c] = line(s);
      if (!rdy(s)) low_rdy++;
      drive(s, 1'($urandom), 8'($urandom));
    end
    @(negedge clk);
    drive(s, 1'b0, 8'($urandom));
    check("bit_starts", first_v, exp_f);
    check("bit_ends", last_v, exp_f);
    check("busy_cycles", low_rdy, 10 * c);
    check("idle_line", line(s), 1);
    check("rdy_post", rdy(s), 1);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad = 0;
    int highs = 0;
    int lows = 0;
    logic [9:0] first_v;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_line", line(0), 1);
    check("rst_rdy", rdy(0), 1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!(line(0) && rdy(0) && line(1) && rdy(1))) bad++;
    end
    check("idle_hold", bad, 0);
    // 8'hA5 on the default-rate instance: 0,1,0,1,0,0,1,0,1,1 on the wire
    frame(0, 8'hA5);
    // 8'h81 at four clocks per bit: 40-cycle frame
    frame(1, 8'h81);
    for (int i = 0; i < 256; i++) frame(1, 8'(i));
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      frame(0, 8'($urandom));
    end
    // valid_in held through two frames; byte_in changes mid-frame must not leak in
    @(negedge clk);
    drive(0, 1'b1, 8'h00);
    @(posedge clk);
    bad = 0;
    for (int t = 0; t < 9 * 33; t++) begin
      @(negedge clk);
      if (t == 5) drive(0, 1'b1, 8'hFF);
      if (line(0) !== (t < 33 ? 1'b0 : 1'b0)) bad++;
    end
    check("b2b_frame1_low", bad, 0);
    highs = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (line(0) !== 1'b1) break;
      highs++;
    end
    check("b2b_gap", highs, 34);
    drive(0, 1'b0, 8'h00);
    first_v = '0;
    for (int t = 0; t < 330; t++) begin
      if (t > 0) @(negedge clk);
      if (t % 33 == 0) first_v[t / 33] = line(0);
    end
    check("b2b_frame2", first_v, {1'b1, 8'hFF, 1'b0});
    @(negedge clk);
    check("b2b_rdy_post", rdy(0), 1);
    // reset during data bit 3 of 8'h00
    @(negedge clk);
    drive(0, 1'b1, 8'h00);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    repeat (4 * 33 + 10) @(negedge clk);
    check("pre_rst_bit3", line(0), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_line", line(0), 1);
    check("rst_mid_rdy", rdy(0), 1);
    lows = 0;
    for (int t = 0; t < 330; t++) begin
      @(negedge clk);
      if (!line(0)) lows++;
    end
    check("rst_no_tail", lows, 0);
    frame(0, 8'h3C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
